// File: rtl/neuron_driver_if.sv
// Load, Neuron-side and result signals of the neuron_driver sequencer.
// The driver uses the master view; the environment (load source, Neuron,
// result sink) uses the slave view.
interface neuron_driver_if #(
   parameter int N_INPUTS = 64,
   parameter int WGT_W    = 19,
   parameter int PIX_W    = 10,
   parameter int OUT_W    = 26
);
   logic                      Load_valid;
   logic                      Load_ready;
   logic [WGT_W-1:0]          Load_wgt;
   logic [PIX_W-1:0]          Load_pix;
   logic [N_INPUTS*WGT_W-1:0] Wgt_bus;
   logic [N_INPUTS*PIX_W-1:0] Pix_bus;
   logic                      Input_valid;
   logic [OUT_W-1:0]          Neuron_out;
   logic                      Neuron_valid;
   logic [OUT_W-1:0]          Result_data;
   logic                      Result_err;
   logic                      Result_valid;
   logic                      Result_ready;
   logic                      Busy;

   modport master (
      input  Load_valid, Load_wgt, Load_pix, Neuron_out, Neuron_valid, Result_ready,
      output Load_ready, Wgt_bus, Pix_bus, Input_valid, Result_data, Result_err,
             Result_valid, Busy
   );

   modport slave (
      output Load_valid, Load_wgt, Load_pix, Neuron_out, Neuron_valid, Result_ready,
      input  Load_ready, Wgt_bus, Pix_bus, Input_valid, Result_data, Result_err,
             Result_valid, Busy
   );
endinterface

// File: rtl/neuron_driver.sv
// Sequencer around one Neuron: serially fills a weight/pixel bank, fires
// the Neuron once, waits (with a timeout) for its result and hands the
// result downstream over a valid/ready port.
module neuron_driver #(
   parameter int N_INPUTS = 64,
   parameter int WGT_W    = 19,
   parameter int PIX_W    = 10,
   parameter int OUT_W    = 26,
   parameter int IDX_W    = 6,
   parameter int TIMEOUT  = 255
) (
   input logic              clk,
   input logic              GlobalReset,
   input logic              Abort,
   neuron_driver_if.master  bus
);

   typedef enum logic [1:0] {LOAD, FIRE, WAIT, HOLD} state_t;

   state_t                    state, state_nxt;
   logic [IDX_W-1:0]          idx;
   logic [7:0]                wcnt;
   logic [N_INPUTS*WGT_W-1:0] wgt_bank;
   logic [N_INPUTS*PIX_W-1:0] pix_bank;
   logic [OUT_W-1:0]          result_data;
   logic                      result_err;
   logic                      input_valid_q;
   logic                      result_valid_q;
   logic                      busy_q;
   logic                      beat;
   logic                      last_beat;
   logic                      wait_done;

   // An aborting cycle never accepts a beat, so the offered beat is dropped.
   assign beat      = (state == LOAD) && bus.Load_valid && !Abort;
   assign last_beat = beat && (idx == IDX_W'(N_INPUTS - 1));
   assign wait_done = bus.Neuron_valid || (wcnt == 8'(TIMEOUT));

   // Next-state decode; Abort overrides every other transition.
   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (last_beat) state_nxt = FIRE;
         FIRE:    state_nxt = WAIT;
         WAIT:    if (wait_done) state_nxt = HOLD;
         HOLD:    if (bus.Result_ready) state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
      if (Abort) state_nxt = LOAD;
   end

   // State register plus the registered status outputs derived from it.
   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
         state          <= LOAD;
         input_valid_q  <= 1'b0;
         result_valid_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state          <= state_nxt;
         input_valid_q  <= (state_nxt == FIRE);
         result_valid_q <= (state_nxt == HOLD);
         busy_q         <= (state_nxt == FIRE) || (state_nxt == WAIT);
      end
   end

   // Load index: advances per accepted beat, wraps after the last entry.
   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
         idx <= '0;
      end else if (Abort || last_beat) begin
         idx <= '0;
      end else if (beat) begin
         idx <= idx + 1'b1;
      end
   end

   // Wait counter: cleared in FIRE, counts every WAIT cycle until the exit.
   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
         wcnt <= '0;
      end else if (Abort || state == FIRE) begin
         wcnt <= '0;
      end else if (state == WAIT && !wait_done) begin
         wcnt <= wcnt + 8'd1;
      end
   end

   // Bank is written only by accepted beats, so it stays frozen from FIRE
   // through the WAIT exit while the Neuron walks its slices.
   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
         wgt_bank <= '0;
         pix_bank <= '0;
      end else if (beat) begin
         wgt_bank[idx*WGT_W +: WGT_W] <= bus.Load_wgt;
         pix_bank[idx*PIX_W +: PIX_W] <= bus.Load_pix;
      end
   end

   // Result capture on WAIT exit; a Neuron response beats a same-cycle timeout.
   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
         result_data <= '0;
         result_err  <= 1'b0;
      end else if (state == WAIT && !Abort) begin
         if (bus.Neuron_valid) begin
            result_data <= bus.Neuron_out;
            result_err  <= 1'b0;
         end else if (wcnt == 8'(TIMEOUT)) begin
            result_data <= '0;
            result_err  <= 1'b1;
         end
      end
   end

   assign bus.Load_ready   = (state == LOAD);
   assign bus.Wgt_bus      = wgt_bank;
   assign bus.Pix_bus      = pix_bank;
   assign bus.Input_valid  = input_valid_q;
   assign bus.Result_valid = result_valid_q;
   assign bus.Result_data  = result_data;
   assign bus.Result_err   = result_err;
   assign bus.Busy         = busy_q;

endmodule
